// File: rtl/mem_port_seq.sv
// Three-module burst sequencer sharing one single-port SRAM.
// Each module owns a slot; the external arbiter grant selects which slot issues a beat.
module mem_port_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          req_wr,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [8:0]          req_len,
  input  logic [3*DATA_W-1:0] wdata,
  input  logic [1:0]          accmodule,
  output logic [2:0]          done,
  output logic [2:0]          busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rd_valid,
  output logic [1:0]          rd_id,
  output logic [DATA_W-1:0]   rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE,
    S_SUSP
  } slot_state_t;

  slot_state_t       state_q [3];
  slot_state_t       state_d [3];
  logic [2:0]        wr_q;
  logic [2:0]        wr_d;
  logic [ADDR_W-1:0] addr_q  [3];
  logic [ADDR_W-1:0] addr_d  [3];
  logic [2:0]        rem_q   [3];
  logic [2:0]        rem_d   [3];
  logic [2:0]        beat;
  logic [2:0]        last_beat;
  logic [2:0]        busy_d;
  logic              rd_valid_d;
  logic [1:0]        rd_id_d;

  // A beat issues only when the grant points at a slot holding an open burst.
  always_comb begin
    beat      = '0;
    last_beat = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      beat[k]      = (accmodule == 2'(k + 1)) && (state_q[k] != S_IDLE);
      last_beat[k] = beat[k] && (rem_q[k] == '0);
    end
  end

  always_comb begin
    mem_en    = |beat;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (beat[k]) begin
        mem_we    = wr_q[k];
        mem_addr  = addr_q[k];
        mem_wdata = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    wr_d   = wr_q;
    busy_d = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      addr_d[k]  = addr_q[k];
      rem_d[k]   = rem_q[k];
      case (state_q[k])
        S_IDLE: begin
          if (req[k]) begin
            state_d[k] = S_WAIT;
            wr_d[k]    = req_wr[k];
            addr_d[k]  = req_addr[k*ADDR_W +: ADDR_W];
            rem_d[k]   = req_len[k*3 +: 3];
          end
        end
        S_WAIT, S_SUSP: begin
          if (beat[k]) state_d[k] = last_beat[k] ? S_IDLE : S_ACTIVE;
        end
        S_ACTIVE: begin
          if (beat[k]) state_d[k] = last_beat[k] ? S_IDLE : S_ACTIVE;
          else         state_d[k] = S_SUSP;
        end
        default: state_d[k] = S_IDLE;
      endcase
      if (beat[k]) begin
        addr_d[k] = addr_q[k] + 1'b1;
        rem_d[k]  = rem_q[k] - 1'b1;
      end
      busy_d[k] = (state_d[k] != S_IDLE);
    end
  end

  assign rd_valid_d = mem_en & ~mem_we;
  assign rd_id_d    = rd_valid_d ? accmodule : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < 3; k++) begin
        state_q[k] <= S_IDLE;
        addr_q[k]  <= '0;
        rem_q[k]   <= '0;
      end
      wr_q     <= '0;
      done     <= '0;
      busy     <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        addr_q[k]  <= addr_d[k];
        rem_q[k]   <= rem_d[k];
      end
      wr_q     <= wr_d;
      done     <= last_beat;
      busy     <= busy_d;
      rd_valid <= rd_valid_d;
      rd_id    <= rd_id_d;
    end
  end

  // SRAM data arrives in the cycle rd_valid is high; gate it instead of adding a second stage.
  assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_seq.sv
// Self-checking bench for mem_port_seq: vector table, directed corner sequences,
// and randomized traffic against a beat-counting reference model with an SRAM model.
module tb_mem_port_seq;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req, req_wr;
  logic [3*AW-1:0] req_addr;
  logic [8:0]    req_len;
  logic [3*DW-1:0] wdata;
  logic [1:0]    accmodule;
  logic [2:0]    done, busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          rd_valid;
  logic [1:0]    rd_id;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  mem_port_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .wdata(wdata), .accmodule(accmodule), .done(done), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  // SRAM: synchronous read, data visible the cycle after the read beat.
  logic [7:0] sram [256];
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_en && mem_we)  sram[mem_addr] = mem_wdata;
  end

  // Reference model: per module, whether a burst is open, next address, beats left.
  bit         act   [3];
  bit         m_wr  [3];
  logic [7:0] m_addr[3];
  int         m_left[3];
  logic [7:0] ref_mem [256];
  logic [2:0] e_done, e_busy;
  logic       e_rdv;
  logic [1:0] e_rdid;
  logic [7:0] e_rddata;
  logic       cur_bt;
  int         cur_g;
  logic       obs_en;
  logic [7:0] obs_addr;
  int         n_pass, n_total;

  typedef struct {
    logic rst; logic [2:0] rq; logic [2:0] wr; logic [23:0] ad; logic [8:0] ln; logic [1:0] acc;
    logic en; logic we; logic [7:0] maddr; logic rdv; logic [1:0] rdid; logic [2:0] dn; logic [2:0] bz;
  } vec_t;
  vec_t tbl [13];
  logic [1:0] seq25 [8];

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_total++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act_v, exp_v, $time);
  endtask

  task automatic drive_check(input logic rst, input logic [2:0] rq, input logic [2:0] wr,
                             input logic [23:0] ad, input logic [8:0] ln, input logic [1:0] acc);
    logic       ew;
    logic [7:0] ea, ewd;
    reset = rst; req = rq; req_wr = wr; req_addr = ad; req_len = ln; accmodule = acc;
    wdata = 24'($urandom);
    #2;
    cur_g  = int'(acc);
    cur_bt = 1'b0;
    ew = 1'b0; ea = '0; ewd = '0;
    if (cur_g != 0) cur_bt = act[cur_g-1];
    if (cur_bt) begin
      ew  = m_wr[cur_g-1];
      ea  = m_addr[cur_g-1];
      ewd = wdata[(cur_g-1)*8 +: 8];
    end
    chk("mem_en",    32'(mem_en),    32'(cur_bt));
    chk("mem_we",    32'(mem_we),    32'(ew));
    chk("mem_addr",  32'(mem_addr),  32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
    chk("done",      32'(done),      32'(e_done));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("rd_valid",  32'(rd_valid),  32'(e_rdv));
    if (e_rdv) begin
      chk("rd_id",   32'(rd_id),   32'(e_rdid));
      chk("rd_data", 32'(rd_data), 32'(e_rddata));
    end
    chk("done_onehot", 32'($countones(done) <= 1), 32'(1));
    obs_en   = mem_en;
    obs_addr = mem_addr;
  endtask

  task automatic advance();
    logic [2:0] nd;
    logic       nrdv;
    logic [1:0] nrid;
    logic [7:0] nrdat;
    bit         pre [3];
    int         k;
    nd = '0; nrdv = 1'b0; nrid = '0; nrdat = '0;
    pre = act;
    if (cur_bt) begin
      k = cur_g - 1;
      if (m_wr[k]) ref_mem[m_addr[k]] = wdata[k*8 +: 8];
      else begin
        nrdv  = 1'b1;
        nrid  = accmodule;
        nrdat = ref_mem[m_addr[k]];
      end
      m_addr[k] = m_addr[k] + 8'd1;
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) begin
        act[k] = 1'b0;
        nd[k]  = 1'b1;
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (req[j] && !pre[j]) begin
        act[j]    = 1'b1;
        m_wr[j]   = req_wr[j];
        m_addr[j] = req_addr[j*8 +: 8];
        m_left[j] = int'(req_len[j*3 +: 3]) + 1;
      end
    end
    if (reset) begin
      for (int j = 0; j < 3; j++) act[j] = 1'b0;
      nd = '0; nrdv = 1'b0; nrid = '0;
    end
    e_done = nd; e_rdv = nrdv; e_rdid = nrid; e_rddata = nrdat;
    e_busy = {act[2], act[1], act[0]};
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic [2:0] rq, input logic [2:0] wr,
                      input logic [23:0] ad, input logic [8:0] ln, input logic [1:0] acc);
    drive_check(rst, rq, wr, ad, ln, acc);
    advance();
  endtask

  initial begin
    int m3_beats;
    logic [7:0] m3_next;
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    for (int j = 0; j < 3; j++) begin
      act[j] = 1'b0; m_wr[j] = 1'b0; m_addr[j] = '0; m_left[j] = 0;
    end
    e_done = '0; e_busy = '0; e_rdv = 1'b0; e_rdid = '0; e_rddata = '0;
    reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_len = '0; wdata = '0; accmodule = '0;

    //            rst  req     wr      addr        len             acc    en   we   maddr  rdv  rdid   done    busy
    tbl[0]  = '{1'b0, 3'b001, 3'b000, 24'h000010, 9'd3,          2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b01, 1'b1, 1'b0, 8'h10, 1'b0, 2'b00, 3'b000, 3'b001};
    tbl[2]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b01, 1'b1, 1'b0, 8'h11, 1'b1, 2'b01, 3'b000, 3'b001};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b01, 1'b1, 1'b0, 8'h12, 1'b1, 2'b01, 3'b000, 3'b001};
    tbl[4]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b01, 1'b1, 1'b0, 8'h13, 1'b1, 2'b01, 3'b000, 3'b001};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 3'b001, 3'b000};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 3'b010, 3'b010, 24'h00FE00, 9'b000_010_000, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b10, 1'b1, 1'b1, 8'hFE, 1'b0, 2'b00, 3'b000, 3'b010};
    tbl[9]  = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b10, 1'b1, 1'b1, 8'hFF, 1'b0, 2'b00, 3'b000, 3'b010};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b10, 1'b1, 1'b1, 8'h00, 1'b0, 2'b00, 3'b000, 3'b010};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b010, 3'b000};
    tbl[12] = '{1'b0, 3'b000, 3'b000, 24'h000000, 9'd0,          2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 3'b000};
    seq25 = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};

    @(posedge clk);
    #1;
    step(1'b1, '0, '0, '0, '0, 2'b00);
    chk("rst_busy",     32'(busy),     32'(0));
    chk("rst_done",     32'(done),     32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_id",    32'(rd_id),    32'(0));
    chk("rst_rd_data",  32'(rd_data),  32'(0));

    // Vector table: M1 read burst at 0x10, then M2 write burst wrapping FE..00.
    for (int i = 0; i < 13; i++) begin
      drive_check(tbl[i].rst, tbl[i].rq, tbl[i].wr, tbl[i].ad, tbl[i].ln, tbl[i].acc);
      chk($sformatf("tbl%0d_en", i),    32'(mem_en),   32'(tbl[i].en));
      chk($sformatf("tbl%0d_we", i),    32'(mem_we),   32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i),  32'(mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("tbl%0d_rdv", i),   32'(rd_valid), 32'(tbl[i].rdv));
      if (tbl[i].rdv) chk($sformatf("tbl%0d_rdid", i), 32'(rd_id), 32'(tbl[i].rdid));
      chk($sformatf("tbl%0d_done", i),  32'(done),     32'(tbl[i].dn));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].bz));
      advance();
    end

    // M3 read len 5 preempted by a one-beat M1 read; M3 addresses must stay contiguous.
    step(1'b0, 3'b101, 3'b000, 24'h400080, 9'b101_000_000, 2'b00);
    m3_beats = 0;
    m3_next  = 8'h40;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, '0, '0, seq25[i]);
      if (seq25[i] == 2'd3 && obs_en) begin
        chk("m3_addr", 32'(obs_addr), 32'(m3_next));
        m3_next  = m3_next + 8'd1;
        m3_beats = m3_beats + 1;
      end
    end
    chk("m3_beats", 32'(m3_beats), 32'(6));

    // Simultaneous M2 write and M3 read requests; each finishes only under its own grant.
    step(1'b0, 3'b110, 3'b010, 24'h30A000, 9'b010_001_000, 2'b00);
    chk("busy_110", 32'(busy), 32'(3'b110));
    step(1'b0, '0, '0, '0, '0, 2'b01);
    step(1'b0, '0, '0, '0, '0, 2'b01);
    step(1'b0, '0, '0, '0, '0, 2'b11);
    step(1'b0, '0, '0, '0, '0, 2'b11);
    step(1'b0, '0, '0, '0, '0, 2'b11);
    chk("done_m3", 32'(done), 32'(3'b100));
    step(1'b0, '0, '0, '0, '0, 2'b10);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    chk("done_m2", 32'(done), 32'(3'b010));
    step(1'b0, '0, '0, '0, '0, 2'b00);

    // Request on the last-beat cycle is dropped; request on the done cycle is taken.
    step(1'b0, 3'b001, 3'b000, 24'h000020, 9'd1, 2'b01);
    step(1'b0, '0, '0, '0, '0, 2'b01);
    step(1'b0, 3'b001, 3'b000, 24'h000099, 9'd5, 2'b01);
    chk("done_m1_last",  32'(done),    32'(3'b001));
    chk("busy0_ignored", 32'(busy[0]), 32'(0));
    step(1'b0, 3'b001, 3'b000, 24'h000050, 9'd0, 2'b00);
    chk("busy0_taken",   32'(busy[0]), 32'(1));
    step(1'b0, '0, '0, '0, '0, 2'b01);
    chk("done_m1_again", 32'(done),    32'(3'b001));
    step(1'b0, '0, '0, '0, '0, 2'b00);

    // Reset in the middle of an M2 read burst, with a read beat in flight.
    step(1'b0, 3'b010, 3'b000, 24'h006000, 9'b000_111_000, 2'b10);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    step(1'b1, '0, '0, '0, '0, 2'b10);
    chk("abort_busy",  32'(busy),     32'(0));
    chk("abort_done",  32'(done),     32'(0));
    chk("abort_rdv",   32'(rd_valid), 32'(0));
    step(1'b0, 3'b010, 3'b000, 24'h007000, 9'b000_001_000, 2'b00);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    step(1'b0, '0, '0, '0, '0, 2'b10);
    chk("after_abort_done", 32'(done), 32'(3'b010));
    step(1'b0, '0, '0, '0, '0, 2'b00);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 49) == 0),
           3'($urandom) & 3'($urandom),
           3'($urandom),
           24'($urandom),
           9'($urandom),
           2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_seq.md
MEM_PORT_SEQ -- requirements
Module: mem_port_seq

Interface
REQ-001 Parameter ADDR_W, 8, memory address width.
REQ-002 Parameter DATA_W, 8, memory data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-004 The block SHALL expose the following ports, one line each (name, direction, width, meaning):
- req  in  3  per-module one-cycle request pulse, bit0=M1, bit1=M2, bit2=M3.
- req_wr  in  3  per-module write flag, sampled with req.
- req_addr  in  3*ADDR_W  per-module start address, sampled with req; slice k = bits [k*ADDR_W +: ADDR_W].
- req_len  in  9  per-module beats-1 (0..7), sampled with req; slice k = bits [3k +: 3].
- wdata  in  3*DATA_W  per-module write data, sampled on every write beat.
- accmodule  in  2  grant from the arbiter: 00=none, 01=M1, 10=M2, 11=M3.
- done  out  3  one-cycle completion pulse per module.
- busy  out  3  per-module slot occupied.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read beat.
- rd_valid  out  1  registered read-return strobe.
- rd_id  out  2  module of the returned read, same encoding as accmodule.
- rd_data  out  DATA_W  returned read data.

Function
REQ-005 The block SHALL keep one slot per module holding: state, wr, current addr, remaining beats.
REQ-006 Slot FSM: IDLE -> WAIT on req[k]; WAIT -> ACTIVE on first issued beat; ACTIVE -> SUSP when accmodule != k with beats remaining; SUSP -> ACTIVE on the next issued beat; ACTIVE -> IDLE in the cycle after the last beat.
REQ-007 req[k] SHALL be accepted only when slot k is IDLE at that edge; req[k] arriving while the slot is non-IDLE (including on the last-beat cycle) SHALL be ignored.
REQ-008 Requests from several modules in the same cycle SHALL all latch independently.
REQ-009 Beat issue is combinational: mem_en=1 iff accmodule=k (k nonzero) and slot k is WAIT, ACTIVE or SUSP.
REQ-010 On an issued beat, mem_we=slot wr, mem_addr=slot addr, and mem_wdata=wdata slice k.
REQ-011 When mem_en=0, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-012 Each issued beat SHALL increment the slot addr modulo 2^ADDR_W (FF wraps to 00) and decrement the remaining count.
REQ-013 A burst SHALL be exactly req_len+1 beats, in any interleaving of grants.
REQ-014 Progress SHALL be preserved across preemption; no beat is repeated or skipped.
REQ-015 A grant to a non-requesting slot, or accmodule=00, SHALL issue nothing.
REQ-016 For each read beat, the block SHALL register rd_valid=1, rd_id=k and rd_data=mem_rdata one cycle after the beat; write beats SHALL produce no rd_valid.
REQ-017 done[k] SHALL pulse for exactly one cycle, one cycle after the last beat; for reads it coincides with the last rd_valid.
REQ-018 At most one done bit SHALL be set per cycle.
REQ-019 busy[k]=1 iff slot k is not IDLE, registered.
REQ-020 A req[k] sampled in the same cycle that done[k] is high SHALL be accepted.

Reset
REQ-021 While reset=1 at an edge, all slots SHALL go to IDLE and all registered outputs (done, busy, rd_valid, rd_id, rd_data) SHALL be 0.
REQ-022 A reset during a burst SHALL abort it: no done pulse, and the in-flight read return is dropped (rd_valid=0 in the following cycle).

Verification
REQ-023 M1 read, addr=10, len=3, accmodule=01 held -> mem_addr 10,11,12,13 on 4 consecutive cycles; rd_valid with rd_id=01 on 4 cycles, each one cycle later; done=001 with the 4th rd_valid.
REQ-024 M2 write, addr=FE, len=2 -> mem_we=1 at addresses FE, FF, 00; done=010 one cycle after the beat at 00; rd_valid stays 0.
REQ-025 M3 read len=5; accmodule 11 for 2 cycles, 01 (M1 len=0 pending) for 1 cycle, then 11 -> M3 addr sequence resumes contiguously; total 6 M3 beats; done=001 then done=100, never on the same cycle.
REQ-026 req=110 in the same cycle -> busy=110 next cycle; each burst completes only under its own grant.
REQ-027 req[0] during M1's last-beat cycle -> ignored; busy[0]=0 after done; req[0] on the done cycle -> accepted, busy[0]=1 next cycle.
REQ-028 reset asserted mid-M2 burst -> next cycle busy=000, done=000, rd_valid=0; a subsequent request works normally.
